// File: rtl/ctr_game_pkg.sv
// Shared encodings and constants for the counter game: who-won codes,
// step-select codes and the event limit that ends a game.
package ctr_game_pkg;

    localparam logic [1:0] WHO_NONE   = 2'b00;
    localparam logic [1:0] WHO_LOSER  = 2'b01;
    localparam logic [1:0] WHO_WINNER = 2'b10;

    localparam logic [1:0] CTRL_INC1 = 2'b00;
    localparam logic [1:0] CTRL_INC2 = 2'b01;
    localparam logic [1:0] CTRL_DEC1 = 2'b10;
    localparam logic [1:0] CTRL_DEC2 = 2'b11;

    localparam logic [3:0] GAME_LIMIT = 4'd15;

    // Event counter advance; the game ends at GAME_LIMIT so it never wraps.
    function automatic logic [3:0] count_add(input logic [3:0] count, input logic evt);
        return count + {3'b000, evt};
    endfunction

endpackage

// File: rtl/ctr_game_score.sv
// Winner/loser event counters plus the gameover pulse and who-won code.
// Priority: reset > init (hold) > gameover clear > normal counting.
module ctr_game_score
    import ctr_game_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       init,
    input  logic       win_evt,
    input  logic       lose_evt,
    output logic [3:0] winner_count,
    output logic [3:0] loser_count,
    output logic       gameover,
    output logic [1:0] who
);

    logic [3:0] winner_count_r;
    logic [3:0] loser_count_r;
    logic       gameover_r;
    logic [1:0] who_r;

    logic [3:0] winner_count_next_s;
    logic [3:0] loser_count_next_s;
    logic       gameover_next_s;
    logic [1:0] who_next_s;

    // Next counts and end-of-game decision for a normal cycle; loser takes precedence.
    always_comb begin
        winner_count_next_s = count_add(winner_count_r, win_evt);
        loser_count_next_s  = count_add(loser_count_r, lose_evt);
        gameover_next_s     = 1'b0;
        who_next_s          = WHO_NONE;
        if (loser_count_next_s == GAME_LIMIT) begin
            gameover_next_s = 1'b1;
            who_next_s      = WHO_LOSER;
        end else if (winner_count_next_s == GAME_LIMIT) begin
            gameover_next_s = 1'b1;
            who_next_s      = WHO_WINNER;
        end else begin
            gameover_next_s = 1'b0;
            who_next_s      = WHO_NONE;
        end
    end

    // Score state register; init freezes everything so a pending clear waits for init to drop.
    always_ff @(posedge clock) begin
        if (reset) begin
            winner_count_r <= 4'd0;
            loser_count_r  <= 4'd0;
            gameover_r     <= 1'b0;
            who_r          <= WHO_NONE;
        end else if (init) begin
            winner_count_r <= winner_count_r;
            loser_count_r  <= loser_count_r;
            gameover_r     <= gameover_r;
            who_r          <= who_r;
        end else if (gameover_r) begin
            winner_count_r <= 4'd0;
            loser_count_r  <= 4'd0;
            gameover_r     <= 1'b0;
            who_r          <= WHO_NONE;
        end else begin
            winner_count_r <= winner_count_next_s;
            loser_count_r  <= loser_count_next_s;
            gameover_r     <= gameover_next_s;
            who_r          <= who_next_s;
        end
    end

    assign winner_count = winner_count_r;
    assign loser_count  = loser_count_r;
    assign gameover     = gameover_r;
    assign who          = who_r;

endmodule

// File: rtl/ctr_game.sv
// Counter game top: a modulo-2^N stepping counter whose wrap-end values
// raise winner/loser pulses that are tallied by ctr_game_score.
module ctr_game
    import ctr_game_pkg::*;
#(
    parameter int COUNTER_SIZE = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    init,
    input  logic [COUNTER_SIZE-1:0] initial_value,
    input  logic [1:0]              control,
    output logic [COUNTER_SIZE-1:0] counter,
    output logic                    winner,
    output logic                    loser,
    output logic [3:0]              winner_count,
    output logic [3:0]              loser_count,
    output logic                    gameover,
    output logic [1:0]              who
);

    logic [COUNTER_SIZE-1:0] counter_r;
    logic                    winner_r;
    logic                    loser_r;
    logic [COUNTER_SIZE-1:0] counter_next_s;
    logic                    win_evt_s;
    logic                    lose_evt_s;
    logic                    gameover_s;

    // Events are judged on the value held before this cycle's step.
    assign win_evt_s  = (counter_r == {COUNTER_SIZE{1'b1}});
    assign lose_evt_s = (counter_r == {COUNTER_SIZE{1'b0}});

    // Step selection; arithmetic wraps naturally at the counter width.
    always_comb begin
        counter_next_s = counter_r;
        case (control)
            CTRL_INC1: counter_next_s = counter_r + COUNTER_SIZE'(1);
            CTRL_INC2: counter_next_s = counter_r + COUNTER_SIZE'(2);
            CTRL_DEC1: counter_next_s = counter_r - COUNTER_SIZE'(1);
            CTRL_DEC2: counter_next_s = counter_r - COUNTER_SIZE'(2);
            default:   counter_next_s = counter_r;
        endcase
    end

    // Counter and pulse registers; a gameover cycle resets the board instead of stepping.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter_r <= {COUNTER_SIZE{1'b0}};
            winner_r  <= 1'b0;
            loser_r   <= 1'b0;
        end else if (init) begin
            counter_r <= initial_value;
            winner_r  <= 1'b0;
            loser_r   <= 1'b0;
        end else if (gameover_s) begin
            counter_r <= {COUNTER_SIZE{1'b0}};
            winner_r  <= 1'b0;
            loser_r   <= 1'b0;
        end else begin
            counter_r <= counter_next_s;
            winner_r  <= win_evt_s;
            loser_r   <= lose_evt_s;
        end
    end

    ctr_game_score u_score (
        .clock        (clock),
        .reset        (reset),
        .init         (init),
        .win_evt      (win_evt_s),
        .lose_evt     (lose_evt_s),
        .winner_count (winner_count),
        .loser_count  (loser_count),
        .gameover     (gameover_s),
        .who          (who)
    );

    assign counter  = counter_r;
    assign winner   = winner_r;
    assign loser    = loser_r;
    assign gameover = gameover_s;

endmodule

// File: tb/tb_ctr_game.sv
// Directed bench for ctr_game (N = 3): a behavioural model pushes expected
// outputs to a scoreboard queue, popped and compared after each clock edge.
module tb_ctr_game;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b0;
    logic [2:0] initial_value = 3'd0;
    logic [1:0] control = 2'b00;
    logic [2:0] counter;
    logic       winner;
    logic       loser;
    logic [3:0] winner_count;
    logic [3:0] loser_count;
    logic       gameover;
    logic [1:0] who;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // model state
    logic [2:0] m_counter = 3'd0;
    logic       m_win = 1'b0;
    logic       m_lose = 1'b0;
    logic [3:0] m_wc = 4'd0;
    logic [3:0] m_lc = 4'd0;
    logic       m_go = 1'b0;
    logic [1:0] m_who = 2'b00;

    logic [15:0] exp_q[$];

    ctr_game #(.COUNTER_SIZE(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .init          (init),
        .initial_value (initial_value),
        .control       (control),
        .counter       (counter),
        .winner        (winner),
        .loser         (loser),
        .winner_count  (winner_count),
        .loser_count   (loser_count),
        .gameover      (gameover),
        .who           (who)
    );

    always #5 clock = ~clock;

    task automatic model(input logic r, input logic i, input logic [2:0] v, input logic [1:0] c);
        logic [2:0] step;
        if (r) begin
            m_counter = 3'd0; m_win = 1'b0; m_lose = 1'b0;
            m_wc = 4'd0; m_lc = 4'd0; m_go = 1'b0; m_who = 2'b00;
        end else if (i) begin
            m_counter = v; m_win = 1'b0; m_lose = 1'b0;
        end else if (m_go) begin
            m_counter = 3'd0; m_win = 1'b0; m_lose = 1'b0;
            m_wc = 4'd0; m_lc = 4'd0; m_go = 1'b0; m_who = 2'b00;
        end else begin
            m_lose = (m_counter == 3'd0);
            m_win  = (m_counter == 3'd7);
            step = (c[0] == 1'b1) ? 3'd2 : 3'd1;
            m_counter = (c[1] == 1'b1) ? m_counter - step : m_counter + step;
            if (m_lose) m_lc = m_lc + 4'd1;
            if (m_win)  m_wc = m_wc + 4'd1;
            if (m_lc == 4'd15) begin
                m_go = 1'b1; m_who = 2'b01;
            end else if (m_wc == 4'd15) begin
                m_go = 1'b1; m_who = 2'b10;
            end else begin
                m_go = 1'b0; m_who = 2'b00;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic r, input logic i, input logic [2:0] v,
                       input logic [1:0] c, input string tag);
        logic [15:0] obs;
        logic [15:0] expv;
        reset = r; init = i; initial_value = v; control = c;
        model(r, i, v, c);
        exp_q.push_back({m_counter, m_win, m_lose, m_wc, m_lc, m_go, m_who});
        @(posedge clock);
        #1;
        obs  = {counter, winner, loser, winner_count, loser_count, gameover, who};
        expv = exp_q.pop_front();
        chk(tag, obs, expv);
    endtask

    initial begin
        // reset and first normal cycle
        cyc(1'b1, 1'b0, 3'd0, 2'b00, "reset0");
        cyc(1'b1, 1'b0, 3'd0, 2'b00, "reset1");
        chk("reset_all_zero", {counter, winner, loser, winner_count, loser_count, gameover, who}, 16'h0000);
        cyc(1'b0, 1'b0, 3'd0, 2'b00, "first_normal");
        chk("first_loser", {13'd0, counter, loser}, {13'd0, 3'd1, 1'b1});

        // init 5, +1 steps: 5 6 7 0 1
        cyc(1'b1, 1'b0, 3'd0, 2'b00, "rst_a");
        cyc(1'b0, 1'b1, 3'd5, 2'b00, "init5");
        cyc(1'b0, 1'b0, 3'd0, 2'b00, "inc_6");
        cyc(1'b0, 1'b0, 3'd0, 2'b00, "inc_7");
        cyc(1'b0, 1'b0, 3'd0, 2'b00, "inc_0");
        chk("wrap_winner", {12'd0, counter, winner}, {12'd0, 3'd0, 1'b1});
        cyc(1'b0, 1'b0, 3'd0, 2'b00, "inc_1");
        chk("wrap_loser", {12'd0, counter, winner, loser}, {12'd0, 3'd1, 1'b0, 1'b1});

        // init 1, -2 steps: 1 7 5
        cyc(1'b0, 1'b1, 3'd1, 2'b11, "init1");
        cyc(1'b0, 1'b0, 3'd0, 2'b11, "dec2_7");
        chk("dec2_underflow", {13'd0, counter}, {13'd0, 3'd7});
        cyc(1'b0, 1'b0, 3'd0, 2'b11, "dec2_5");
        chk("dec2_winner", {12'd0, counter, winner}, {12'd0, 3'd5, 1'b1});

        // init 0, +2 steps: loser every 4 cycles
        cyc(1'b0, 1'b1, 3'd0, 2'b01, "init0");
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 3'd0, 2'b01, "inc2");
        // -1 from 0
        cyc(1'b0, 1'b1, 3'd0, 2'b10, "init0b");
        cyc(1'b0, 1'b0, 3'd0, 2'b10, "dec1_7");
        chk("dec1_underflow", {13'd0, counter}, {13'd0, 3'd7});

        // 15 loser events -> gameover who=01, then clear
        cyc(1'b1, 1'b0, 3'd0, 2'b00, "rst_b");
        for (int k = 0; k < 15; k++) begin
            cyc(1'b0, 1'b1, 3'd0, 2'b00, "lose_init");
            cyc(1'b0, 1'b0, 3'd0, 2'b00, "lose_step");
        end
        chk("loser_gameover", {13'd0, gameover, who}, {13'd0, 1'b1, 2'b01});
        cyc(1'b0, 1'b0, 3'd0, 2'b00, "lose_clear");
        chk("loser_clear", {counter, winner, loser, winner_count, loser_count, gameover, who}, 16'h0000);

        // 15 winner events -> gameover who=10, then clear
        for (int k = 0; k < 15; k++) begin
            cyc(1'b0, 1'b1, 3'd7, 2'b00, "win_init");
            cyc(1'b0, 1'b0, 3'd0, 2'b00, "win_step");
        end
        chk("winner_gameover", {9'd0, winner_count, gameover, who}, {9'd0, 4'd15, 1'b1, 2'b10});
        cyc(1'b0, 1'b0, 3'd0, 2'b00, "win_clear");
        chk("winner_clear", {counter, winner, loser, winner_count, loser_count, gameover, who}, 16'h0000);

        // init during gameover defers the clear
        for (int k = 0; k < 15; k++) begin
            cyc(1'b0, 1'b1, 3'd0, 2'b00, "def_init");
            cyc(1'b0, 1'b0, 3'd0, 2'b00, "def_step");
        end
        cyc(1'b0, 1'b1, 3'd3, 2'b00, "def_hold1");
        cyc(1'b0, 1'b1, 3'd4, 2'b00, "def_hold2");
        chk("deferred_hold", {5'd0, counter, loser_count, gameover, who}, {5'd0, 3'd4, 4'd15, 1'b1, 2'b01});
        cyc(1'b0, 1'b0, 3'd0, 2'b00, "def_clear");
        chk("deferred_clear", {counter, winner, loser, winner_count, loser_count, gameover, who}, 16'h0000);

        // reset mid-operation with counter=6, loser_count=9
        for (int k = 0; k < 9; k++) begin
            cyc(1'b0, 1'b1, 3'd0, 2'b00, "mid_init");
            cyc(1'b0, 1'b0, 3'd0, 2'b00, "mid_step");
        end
        cyc(1'b0, 1'b1, 3'd6, 2'b00, "mid_load6");
        chk("mid_state", {9'd0, counter, loser_count}, {9'd0, 3'd6, 4'd9});
        cyc(1'b1, 1'b1, 3'd5, 2'b00, "mid_reset");
        chk("mid_reset_zero", {counter, winner, loser, winner_count, loser_count, gameover, who}, 16'h0000);

        // reset during a gameover cycle
        for (int k = 0; k < 15; k++) begin
            cyc(1'b0, 1'b1, 3'd0, 2'b00, "go_init");
            cyc(1'b0, 1'b0, 3'd0, 2'b00, "go_step");
        end
        cyc(1'b1, 1'b0, 3'd0, 2'b00, "go_reset");
        chk("gameover_reset", {counter, winner, loser, winner_count, loser_count, gameover, who}, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ctr_game.md
CTR_GAME -- requirements
Module: ctr_game

Interface
REQ-001 Parameter COUNTER_SIZE, default 3, SHALL set the counter width N (N >= 2).
REQ-002 clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 init  input  1  load request: counter takes initial_value this cycle.
REQ-005 initial_value  input  N  value loaded when init = 1.
REQ-006 control  input  2  step select: 00 = +1, 01 = +2, 10 = -1, 11 = -2.
REQ-007 counter  output  N  registered counter value.
REQ-008 winner  output  1  registered one-cycle pulse; counter was all-ones.
REQ-009 loser  output  1  registered one-cycle pulse; counter was zero.
REQ-010 winner_count  output  4  number of winner events since the last clear.
REQ-011 loser_count  output  4  number of loser events since the last clear.
REQ-012 gameover  output  1  registered one-cycle pulse; a count reached 15.
REQ-013 who  output  2  00 = none, 01 = loser won the game, 10 = winner won the game; valid while gameover = 1.

Function
REQ-014 Priority per cycle SHALL be: reset > init > gameover clear > normal count.
REQ-015 init = 1: counter <= initial_value; winner <= 0; loser <= 0; winner_count, loser_count, gameover and who SHALL hold.
REQ-016 Gameover clear (init = 0, gameover = 1): counter <= 0, both counts <= 0, winner, loser and gameover <= 0, who <= 00; no stepping occurs this cycle.
REQ-017 Normal cycle: counter <= counter + step, or counter - step, per control, modulo 2^N. Examples for N = 3: 7 + 1 = 0, 7 + 2 = 1, 0 - 1 = 7, 1 - 2 = 7.
REQ-018 Normal cycle: loser <= (pre-update counter == 0); winner <= (pre-update counter == all-ones); the two are mutually exclusive.
REQ-019 Normal cycle: loser_count increments when the loser condition is true; winner_count increments when the winner condition is true.
REQ-020 Normal cycle: if the next loser_count == 15, gameover <= 1 and who <= 01; else if the next winner_count == 15, gameover <= 1 and who <= 10; else gameover <= 0 and who holds 00.
REQ-021 A counter that stays at 0 or all-ones, for example under repeated init, SHALL produce one pulse per normal cycle, so the pulse can stay high on consecutive cycles.
REQ-022 Counts SHALL never exceed 15; gameover always clears them on the next non-init cycle.
REQ-023 If init is asserted while gameover = 1, gameover and who SHALL persist until the first cycle with init = 0, and that cycle performs the clear.

Reset
REQ-024 reset = 1 at a clock edge: counter, winner_count and loser_count <= 0; winner, loser and gameover <= 0; who <= 00.
REQ-025 reset asserted mid-operation, including during a gameover cycle, SHALL override init and all other activity.
REQ-026 The first normal cycle after reset SHALL see counter == 0 and pulse loser.

Structure
REQ-027 A shared package ctr_game_pkg SHALL hold the who encodings (WHO_NONE = 00, WHO_LOSER = 01, WHO_WINNER = 10), the control encodings, and the constant GAME_LIMIT = 15.
REQ-028 A single sub-module, ctr_game_score, SHALL hold the two event counters together with the gameover and who logic; the top module holds the stepping counter and the winner/loser detection.

Verification
REQ-029 reset, then init = 1 with initial_value = 5, then control = 00 -> counter 5, 6, 7, 0, 1; winner = 1 on the cycle counter shows 0; loser = 1 on the cycle counter shows 1.
REQ-030 init with initial_value = 1, then control = 11 -> counter 1, 7, 5; winner pulses once, when counter shows 5.
REQ-031 init with initial_value = 0, then control = 01 -> counter 0, 2, 4, 6, 0, 2, ...; loser pulses every 4 cycles and winner never pulses.
REQ-032 Drive 15 loser events with no winner events -> gameover = 1 and who = 01 for exactly one cycle; on the next cycle counter = 0, both counts = 0, who = 00.
REQ-033 Drive 15 winner events -> gameover = 1 and who = 10, followed by the full clear.
REQ-034 Assert reset for one cycle while counter = 6 and loser_count = 9 -> all outputs 0 on the next cycle; assert init during a gameover cycle -> the clear is deferred until init drops.
